// File: rtl/shift_engine.sv
// Multi-mode shift/rotate/load engine with a one-step-per-cycle sequencer.
// Commands are accepted in IDLE only; each multi-step command ends with a one-cycle done pulse.
module shift_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] P,
    input  logic [2:0]       s,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic             so_r,
    output logic             so_l
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One single-bit step of the latched operation; fill is the live serial input.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SHR:  r = {fill, d[WIDTH-1:1]};
            OP_SHL:  r = {d[WIDTH-2:0], fill};
            OP_ROR:  r = {d[0], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state, data path and registered status decode.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        op_d    = op_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (s)
                        OP_LOAD: begin
                            d_d     = P;
                            state_d = DONE;
                        end
                        OP_CLR: begin
                            d_d     = '0;
                            state_d = DONE;
                        end
                        OP_HOLD: begin
                            state_d = DONE;
                        end
                        default: begin
                            if (count == '0) begin
                                state_d = DONE;
                            end else begin
                                op_d    = s;
                                cnt_d   = count;
                                state_d = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                d_d   = step_fn(d_q, op_q, ser_in);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign D    = d_q;
    assign busy = busy_q;
    assign done = done_q;
    assign so_r = d_q[0];
    assign so_l = d_q[WIDTH-1];

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed vector table, randomized commands
// against an arithmetic reference model, and an asynchronous-reset corner sequence.
module tb_shift_engine;

    logic       clk;
    logic       rst_n;
    logic [7:0] P;
    logic [2:0] s;
    logic       start;
    logic [3:0] count;
    logic       ser_in;
    logic [7:0] D;
    logic       busy;
    logic       done;
    logic       so_r;
    logic       so_l;

    int passed = 0;
    int total  = 0;
    logic [7:0] m_d;

    shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .P      (P),
        .s      (s),
        .start  (start),
        .count  (count),
        .ser_in (ser_in),
        .D      (D),
        .busy   (busy),
        .done   (done),
        .so_r   (so_r),
        .so_l   (so_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] c;
        logic [7:0] p;
        int         fill;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference step in plain integer arithmetic.
    function automatic logic [7:0] mstep(input logic [7:0] d, input int op, input int f);
        int v;
        v = int'(d);
        case (op)
            1: v = (v / 2) + f * 128;
            2: v = (v * 2 + f) % 256;
            4: v = (v / 2) + (v % 2) * 128;
            5: v = (v * 2) % 256 + v / 128;
            6: v = (v / 2) + (v & 128);
            default: v = v;
        endcase
        return 8'(v);
    endfunction

    // Issue one command and follow it through RUN and DONE; fill < 0 means random serial bits.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] c, input logic [7:0] p,
                          input int fill, input bit scramble);
        int steps;
        int fb;
        @(negedge clk);
        start  = 1'b1;
        s      = op;
        count  = c;
        P      = p;
        ser_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        steps = 0;
        if (op == 3'd3) m_d = p;
        else if (op == 3'd7) m_d = 8'h00;
        else if (op != 3'd0 && c != 4'd0) steps = int'(c);
        @(negedge clk);
        if (scramble) begin
            s     = 3'($urandom);
            count = 4'($urandom);
            P     = 8'($urandom);
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < steps; i++) begin
            chk("busy_in_run", busy, 1);
            fb = (fill < 0) ? int'($urandom_range(0, 1)) : fill;
            ser_in = 1'(fb);
            if (scramble) begin
                s     = 3'($urandom);
                count = 4'($urandom);
                P     = 8'($urandom);
            end
            @(posedge clk);
            m_d = mstep(m_d, int'(op), fb);
            @(negedge clk);
            chk("d_step", D, m_d);
        end
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("d_at_done", D, m_d);
        chk("so_r", so_r, m_d[0]);
        chk("so_l", so_l, m_d[7]);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_cleared", done, 0);
        chk("busy_idle", busy, 0);
        chk("d_idle", D, m_d);
    endtask

    initial begin
        tbl[0]  = '{op: 3'd3, c: 4'd0,  p: 8'hA5, fill: 0, exp: 8'hA5};
        tbl[1]  = '{op: 3'd4, c: 4'd3,  p: 8'h00, fill: 0, exp: 8'hB4};
        tbl[2]  = '{op: 3'd3, c: 4'd0,  p: 8'h90, fill: 0, exp: 8'h90};
        tbl[3]  = '{op: 3'd6, c: 4'd2,  p: 8'h00, fill: 0, exp: 8'hE4};
        tbl[4]  = '{op: 3'd3, c: 4'd0,  p: 8'h81, fill: 0, exp: 8'h81};
        tbl[5]  = '{op: 3'd2, c: 4'd1,  p: 8'h00, fill: 1, exp: 8'h03};
        tbl[6]  = '{op: 3'd1, c: 4'd0,  p: 8'hFF, fill: 1, exp: 8'h03};
        tbl[7]  = '{op: 3'd0, c: 4'd5,  p: 8'hFF, fill: 1, exp: 8'h03};
        tbl[8]  = '{op: 3'd7, c: 4'd0,  p: 8'hFF, fill: 0, exp: 8'h00};
        tbl[9]  = '{op: 3'd3, c: 4'd0,  p: 8'h3C, fill: 0, exp: 8'h3C};
        tbl[10] = '{op: 3'd5, c: 4'd8,  p: 8'h00, fill: 1, exp: 8'h3C};
        tbl[11] = '{op: 3'd1, c: 4'd15, p: 8'h00, fill: 1, exp: 8'hFF};
        tbl[12] = '{op: 3'd2, c: 4'd9,  p: 8'h00, fill: 0, exp: 8'h00};
        tbl[13] = '{op: 3'd4, c: 4'd8,  p: 8'h00, fill: 0, exp: 8'h00};

        rst_n  = 1'b0;
        start  = 1'b0;
        s      = 3'd0;
        count  = 4'd0;
        P      = 8'h00;
        ser_in = 1'b0;
        m_d    = 8'h00;
        #1;
        chk("reset_d", D, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_cmd(tbl[i].op, tbl[i].c, tbl[i].p, tbl[i].fill, 1'b0);
            chk($sformatf("tbl_final_%0d", i), D, tbl[i].exp);
        end

        // Command held high with s/count/P churning during RUN and DONE.
        do_cmd(3'd3, 4'd0, 8'h5A, 0, 1'b0);
        do_cmd(3'd4, 4'd5, 8'h00, -1, 1'b1);
        chk("scramble_ror5", D, 8'hD2);

        for (int i = 0; i < 40; i++) begin
            do_cmd(3'($urandom), 4'($urandom), 8'($urandom), -1, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of an 8-step rotate.
        do_cmd(3'd3, 4'd0, 8'h5A, 0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        s     = 3'd4;
        count = 4'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_d", D, 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_d   = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
            chk("no_busy_after_reset", busy, 0);
        end
        do_cmd(3'd3, 4'd0, 8'hC3, 0, 1'b0);
        chk("load_after_reset", D, 8'hC3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data register width in bits (WIDTH >= 2).
REQ-002 The module SHALL have parameter CNT_W, default 4, meaning width of the shift-count input.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port P  input  WIDTH  parallel load data.
REQ-006 The module SHALL have port s  input  3  operation select, sampled only when a command is accepted.
REQ-007 The module SHALL have port start  input  1  command request, level-sampled at clk edge.
REQ-008 The module SHALL have port count  input  CNT_W  number of single-bit steps for shift/rotate modes.
REQ-009 The module SHALL have port ser_in  input  1  serial fill bit for logical shifts.
REQ-010 The module SHALL have port D  output  WIDTH  registered data register.
REQ-011 The module SHALL have port busy  output  1  high while a multi-step operation is executing.
REQ-012 The module SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 The module SHALL have ports so_r and so_l  output  1 each  combinational D[0] and D[WIDTH-1].

Function
REQ-014 The module SHALL decode s as: 0 hold, 1 logical shift right (MSB <= ser_in), 2 logical shift left (LSB <= ser_in), 3 parallel load D <= P, 4 rotate right, 5 rotate left, 6 arithmetic shift right (MSB replicated), 7 clear D <= 0.
REQ-015 The module SHALL implement FSM states IDLE, RUN, DONE; busy = (state == RUN), done = (state == DONE).
REQ-016 In IDLE, start=0 SHALL leave D and state unchanged.
REQ-017 In IDLE with start=1 and s in {3,7}, the module SHALL update D at that edge and go to DONE.
REQ-018 In IDLE with start=1 and s in {0} or count == 0, the module SHALL leave D unchanged and go to DONE.
REQ-019 In IDLE with start=1, s in {1,2,4,5,6}, count = c >= 1, the module SHALL latch s and c at edge k, go to RUN, perform exactly one step at each of edges k+1..k+c, and enter DONE at edge k+c.
REQ-020 ser_in SHALL be sampled at each step edge, not latched at command acceptance.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE; a new command SHALL be accepted no earlier than the edge after DONE.
REQ-022 start, s, count and P SHALL be ignored while in RUN or DONE; changes to s or count during RUN SHALL not affect the running operation.
REQ-023 The remaining-step counter SHALL be CNT_W bits and SHALL never wrap: maximum count 2^CNT_W-1 executes exactly that many steps.
REQ-024 Rotates SHALL preserve all bits; a rotate of count == WIDTH SHALL return D to its starting value.
REQ-025 Logical shifts with count >= WIDTH SHALL leave D filled entirely with the ser_in values sampled at the last WIDTH steps.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, force D = 0, state = IDLE, busy = 0, done = 0, step counter = 0.
REQ-027 Reset asserted during RUN SHALL abandon the operation; no done pulse SHALL follow deassertion.
REQ-028 After rst_n rises, the first command SHALL be accepted at the first rising clk edge sampling start=1.

Verification (WIDTH=8, CNT_W=4)
REQ-029 Load: s=3, P=8'hA5, start=1 one cycle -> D=8'hA5 after that edge, done=1 exactly one cycle, busy never high.
REQ-030 Rotate right: D=8'hA5, s=4, count=3, start pulse -> busy high 3 cycles, D steps D2, 69, B4, then done=1 one cycle, D=8'hB4.
REQ-031 Arithmetic shift: D=8'h90, s=6, count=2 -> D=8'hC8 then 8'hE4, done pulse after second step.
REQ-032 Shift left with fill: D=8'h81, s=2, ser_in=1, count=1 -> D=8'h03, so_l=0, so_r=1.
REQ-033 Protocol: count=0 with s=1 -> done next cycle, D unchanged; start held high and s/count changed during RUN -> ignored, original operation completes, next command accepted only after DONE.
REQ-034 Reset mid-RUN: assert rst_n=0 between clk edges during an 8-step rotate -> D=0, busy=0 immediately, no done after release.
